// File: rtl/axis_packet_arbiter.sv
// Purpose : merges INPUT_NUMBER AXI-Stream inputs onto one output. Arbitration is
//           round-robin and happens only on routing-header beats. The grant stays
//           locked to one input until that input's TLAST beat has handshaked.
// Latency : 1 cycle from header valid to the first forwarded beat. With ARB_OUT_SKID_EN
//           defined there is 1 more cycle.
// Backpr. : out.TREADY is passed to the granted input only. Every other input is stalled.
//           With ARB_OUT_SKID_EN the arbiter side sees a registered ready from a 2-entry skid.
//
// Optional macros:
//   ARB_OUT_SKID_EN - inserts a 2-entry skid buffer between the arbiter and the out port.
//   TID_PRESENT / TDEST_PRESENT / TUSER_PRESENT - add the TID / TDEST / TUSER sidebands.
//
// Ports:
//   clk, rst_n          - single rising-edge clock and asynchronous active-low reset
//   i_s_tvalid/tdata/tlast[/tid/tdest/tuser], o_s_tready
//                       - one slave stream per input (packed per-input arrays)
//   o_m_tvalid/tdata/tlast[/tid/tdest/tuser], i_m_tready
//                       - the merged master stream
//   o_current_grant     - index of the locked input, or of the last granted input
//   o_grant_valid       - high while a packet is locked
module axis_packet_arbiter #(
  parameter int DATA_WIDTH         = 32,
  parameter int INPUT_NUMBER       = 5,
  parameter int INPUT_NUMBER_WIDTH = $clog2(INPUT_NUMBER),
  parameter int PACKET_TYPE_WIDTH  = 4,
  parameter logic [PACKET_TYPE_WIDTH-1:0] ROUTING_HEADER = PACKET_TYPE_WIDTH'(8)
`ifdef TID_PRESENT
  , parameter int ID_WIDTH = 4
`endif
`ifdef TDEST_PRESENT
  , parameter int DEST_WIDTH = 4
`endif
`ifdef TUSER_PRESENT
  , parameter int USER_WIDTH = 4
`endif
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [INPUT_NUMBER-1:0]                    i_s_tvalid,
  input  logic [INPUT_NUMBER-1:0][DATA_WIDTH-1:0]    i_s_tdata,
  input  logic [INPUT_NUMBER-1:0]                    i_s_tlast,
`ifdef TID_PRESENT
  input  logic [INPUT_NUMBER-1:0][ID_WIDTH-1:0]      i_s_tid,
  output logic [ID_WIDTH-1:0]                        o_m_tid,
`endif
`ifdef TDEST_PRESENT
  input  logic [INPUT_NUMBER-1:0][DEST_WIDTH-1:0]    i_s_tdest,
  output logic [DEST_WIDTH-1:0]                      o_m_tdest,
`endif
`ifdef TUSER_PRESENT
  input  logic [INPUT_NUMBER-1:0][USER_WIDTH-1:0]    i_s_tuser,
  output logic [USER_WIDTH-1:0]                      o_m_tuser,
`endif
  output logic [INPUT_NUMBER-1:0]                    o_s_tready,
  output logic                                       o_m_tvalid,
  output logic [DATA_WIDTH-1:0]                      o_m_tdata,
  output logic                                       o_m_tlast,
  input  logic                                       i_m_tready,
  output logic [INPUT_NUMBER_WIDTH-1:0]              o_current_grant,
  output logic                                       o_grant_valid
);

  typedef enum logic {IDLE, LOCKED} state_t;

  // One forwarded beat: the payload plus whichever sidebands are compiled in.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
`ifdef TID_PRESENT
    logic [ID_WIDTH-1:0]   id;
`endif
`ifdef TDEST_PRESENT
    logic [DEST_WIDTH-1:0] dest;
`endif
`ifdef TUSER_PRESENT
    logic [USER_WIDTH-1:0] user;
`endif
  } beat_t;

  state_t                        r_state;
  logic [INPUT_NUMBER_WIDTH-1:0] r_grant;
  logic [INPUT_NUMBER_WIDTH-1:0] r_rr_ptr;

  logic [INPUT_NUMBER-1:0]       w_hdr;
  logic                          w_any_req;
  logic [INPUT_NUMBER_WIDTH-1:0] w_winner;
  logic                          w_arb_vld;
  logic                          w_arb_rdy;
  beat_t                         w_arb_beat;
  beat_t                         w_out_beat;

  // Header detection looks only at the packet-type field in the top bits of TDATA.
  for (genvar g = 0; g < INPUT_NUMBER; g++) begin : g_hdr
    assign w_hdr[g] = i_s_tvalid[g] &&
                      (i_s_tdata[g][DATA_WIDTH-1 -: PACKET_TYPE_WIDTH] == ROUTING_HEADER);
  end

  // Round-robin scan that starts at r_rr_ptr. The first header found wins.
  always_comb begin
    int                            v_idx;
    logic [INPUT_NUMBER_WIDTH-1:0] v_sel;
    w_any_req = 1'b0;
    w_winner  = '0;
    v_idx     = 0;
    v_sel     = '0;
    for (int k = 0; k < INPUT_NUMBER; k++) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= INPUT_NUMBER) begin
        v_idx = v_idx - INPUT_NUMBER;
      end
      v_sel = v_idx[INPUT_NUMBER_WIDTH-1:0];
      if (!w_any_req && w_hdr[v_sel]) begin
        w_any_req = 1'b1;
        w_winner  = v_sel;
      end
    end
  end

  // The arbiter-side stream is driven from the locked input only. It is all zeros otherwise.
  assign w_arb_vld = (r_state == LOCKED) && i_s_tvalid[r_grant];

  always_comb begin
    w_arb_beat = '0;
    if (w_arb_vld) begin
      w_arb_beat.data = i_s_tdata[r_grant];
      w_arb_beat.last = i_s_tlast[r_grant];
`ifdef TID_PRESENT
      w_arb_beat.id   = i_s_tid[r_grant];
`endif
`ifdef TDEST_PRESENT
      w_arb_beat.dest = i_s_tdest[r_grant];
`endif
`ifdef TUSER_PRESENT
      w_arb_beat.user = i_s_tuser[r_grant];
`endif
    end
  end

  // Ready is routed to the granted input even when it is not valid. All other inputs see 0.
  always_comb begin
    o_s_tready = '0;
    if ((r_state == LOCKED) && w_arb_rdy) begin
      o_s_tready[r_grant] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant <= w_winner;
            r_state <= LOCKED;
          end
        end
        LOCKED: begin
          // Release on the TLAST handshake. The next scan starts just past this grant.
          if (w_arb_vld && w_arb_rdy && w_arb_beat.last) begin
            r_state  <= IDLE;
            r_rr_ptr <= (r_grant == INPUT_NUMBER_WIDTH'(INPUT_NUMBER - 1)) ?
                        '0 : r_grant + INPUT_NUMBER_WIDTH'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ARB_OUT_SKID_EN
  // 2-entry skid buffer. The ready it gives back is registered. It says "not full next
  // cycle", so a push can never overflow, and a steady stream runs at one beat per
  // cycle under this ready.
  beat_t      r_skid [2];
  logic [1:0] r_skid_cnt;
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic       r_skid_rdy;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_cnt_nxt;

  assign w_arb_rdy = r_skid_rdy;
  assign w_push    = w_arb_vld && r_skid_rdy;
  assign w_pop     = (r_skid_cnt != 2'd0) && i_m_tready;

  always_comb begin
    w_cnt_nxt = r_skid_cnt;
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_skid_cnt + 2'd1;
    end else if (!w_push && w_pop) begin
      w_cnt_nxt = r_skid_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid[0]  <= '0;
      r_skid[1]  <= '0;
      r_skid_cnt <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_skid_rdy <= 1'b0;
    end else begin
      if (w_push) begin
        r_skid[r_wr_ptr] <= w_arb_beat;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_skid_cnt <= w_cnt_nxt;
      r_skid_rdy <= (w_cnt_nxt != 2'd2);
    end
  end

  assign o_m_tvalid = (r_skid_cnt != 2'd0);
  assign w_out_beat = o_m_tvalid ? r_skid[r_rd_ptr] : '0;
`else
  assign w_arb_rdy  = i_m_tready;
  assign o_m_tvalid = w_arb_vld;
  assign w_out_beat = w_arb_beat;
`endif

  assign o_m_tdata = w_out_beat.data;
  assign o_m_tlast = w_out_beat.last;
`ifdef TID_PRESENT
  assign o_m_tid   = w_out_beat.id;
`endif
`ifdef TDEST_PRESENT
  assign o_m_tdest = w_out_beat.dest;
`endif
`ifdef TUSER_PRESENT
  assign o_m_tuser = w_out_beat.user;
`endif

  assign o_current_grant = r_grant;
  assign o_grant_valid   = (r_state == LOCKED);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Purpose : directed bench for axis_packet_arbiter in its default build.
// Latency : cycle-by-cycle vectors; inputs are driven at negedge and checked 1 ns later.
// Backpr. : out.TREADY is driven from the vectors and from the stall window.
module tb_axis_packet_arbiter;

  logic             clk;
  logic             rst_n;
  logic [4:0]       s_vld;
  logic [4:0][31:0] s_dat;
  logic [4:0]       s_last;
  logic [4:0]       s_rdy;
  logic             m_vld;
  logic [31:0]      m_dat;
  logic             m_last;
  logic             m_rdy;
  logic [2:0]       cur_grant;
  logic             grant_vld;

  int n_chk = 0;
  int n_err = 0;

  axis_packet_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_s_tvalid      (s_vld),
    .i_s_tdata       (s_dat),
    .i_s_tlast       (s_last),
    .o_s_tready      (s_rdy),
    .o_m_tvalid      (m_vld),
    .o_m_tdata       (m_dat),
    .o_m_tlast       (m_last),
    .i_m_tready      (m_rdy),
    .o_current_grant (cur_grant),
    .o_grant_valid   (grant_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]       vld;
    logic [4:0][31:0] dat;
    logic [4:0]       last;
    logic             rdy;
    logic             e_vld;
    logic [31:0]      e_dat;
    logic             e_last;
    logic [4:0]       e_trdy;
    logic             e_gv;
    logic [2:0]       e_cg;
  } vec_t;

  function automatic vec_t v(input logic [4:0] vld, input logic [31:0] d0, d1, d2, d3, d4,
                             input logic [4:0] last, input logic rdy, input logic ev,
                             input logic [31:0] ed, input logic el, input logic [4:0] et,
                             input logic eg, input logic [2:0] ec);
    vec_t r;
    r.vld = vld; r.dat[0] = d0; r.dat[1] = d1; r.dat[2] = d2; r.dat[3] = d3; r.dat[4] = d4;
    r.last = last; r.rdy = rdy; r.e_vld = ev; r.e_dat = ed; r.e_last = el;
    r.e_trdy = et; r.e_gv = eg; r.e_cg = ec;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm, input logic [2:0] ec);
    chk({nm, " tvalid"}, 32'(m_vld), 0);
    chk({nm, " tdata"}, m_dat, 0);
    chk({nm, " tready"}, 32'(s_rdy), 0);
    chk({nm, " grant_valid"}, 32'(grant_vld), 0);
    chk({nm, " current_grant"}, 32'(cur_grant), 32'(ec));
  endtask

  vec_t tbl [18];
  logic [32:0] beats [4];
  logic [32:0] rx_q [$];

  initial begin
    // Header beats carry type 4'h8 in the top nibble. Data beats carry 4'h0 there.
    tbl[0]  = v(5'b00100, 0, 0, 32'h80000002, 0, 0, 5'b00000, 1, 0, 0, 0, 5'b00000, 0, 0);
    tbl[1]  = v(5'b00100, 0, 0, 32'h80000002, 0, 0, 5'b00000, 1, 1, 32'h80000002, 0, 5'b00100, 1, 2);
    tbl[2]  = v(5'b00100, 0, 0, 32'h000000A1, 0, 0, 5'b00000, 1, 1, 32'h000000A1, 0, 5'b00100, 1, 2);
    tbl[3]  = v(5'b00100, 0, 0, 32'h000000A2, 0, 0, 5'b00000, 1, 1, 32'h000000A2, 0, 5'b00100, 1, 2);
    tbl[4]  = v(5'b00100, 0, 0, 32'h000000A3, 0, 0, 5'b00100, 1, 1, 32'h000000A3, 1, 5'b00100, 1, 2);
    tbl[5]  = v(5'b00000, 0, 0, 0, 0, 0, 5'b00000, 1, 0, 0, 0, 5'b00000, 0, 2);
    // rr_ptr is 3 here. Inputs 0 and 3 contend, so 3 wins and 0's single-beat header waits.
    tbl[6]  = v(5'b01001, 32'h80000010, 0, 0, 32'h80000030, 0, 5'b00001, 1, 0, 0, 0, 5'b00000, 0, 2);
    tbl[7]  = v(5'b01001, 32'h80000010, 0, 0, 32'h80000030, 0, 5'b00001, 1, 1, 32'h80000030, 0, 5'b01000, 1, 3);
    tbl[8]  = v(5'b01001, 32'h80000010, 0, 0, 32'h000000B1, 0, 5'b01001, 1, 1, 32'h000000B1, 1, 5'b01000, 1, 3);
    tbl[9]  = v(5'b00001, 32'h80000010, 0, 0, 0, 0, 5'b00001, 1, 0, 0, 0, 5'b00000, 0, 3);
    tbl[10] = v(5'b00001, 32'h80000010, 0, 0, 0, 0, 5'b00001, 1, 1, 32'h80000010, 1, 5'b00001, 1, 0);
    tbl[11] = v(5'b00000, 0, 0, 0, 0, 0, 5'b00000, 1, 0, 0, 0, 5'b00000, 0, 0);
    // Input 1 shows a non-header beat and input 4 shows a header. Input 4 also sends a
    // header-typed data beat mid-packet, and the grant wraps rr_ptr to 0.
    tbl[12] = v(5'b10010, 0, 32'h00000055, 0, 0, 32'h80000040, 5'b00000, 1, 0, 0, 0, 5'b00000, 0, 0);
    tbl[13] = v(5'b10010, 0, 32'h00000055, 0, 0, 32'h80000040, 5'b00000, 1, 1, 32'h80000040, 0, 5'b10000, 1, 4);
    tbl[14] = v(5'b10010, 0, 32'h00000055, 0, 0, 32'h800000C1, 5'b00000, 1, 1, 32'h800000C1, 0, 5'b10000, 1, 4);
    tbl[15] = v(5'b10010, 0, 32'h00000055, 0, 0, 32'h000000C2, 5'b10000, 1, 1, 32'h000000C2, 1, 5'b10000, 1, 4);
    tbl[16] = v(5'b00010, 0, 32'h00000055, 0, 0, 0, 5'b00000, 1, 0, 0, 0, 5'b00000, 0, 4);
    tbl[17] = v(5'b00010, 0, 32'h00000055, 0, 0, 0, 5'b00000, 1, 0, 0, 0, 5'b00000, 0, 4);

    rst_n  = 1'b0;
    s_vld  = '0;
    s_dat  = '0;
    s_last = '0;
    m_rdy  = 1'b1;
    #1;
    chk_idle("in_reset", 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // After reset is released with no traffic, every output stays at its reset value.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk_idle($sformatf("idle%0d", c), 0);
    end

    for (int r = 0; r < 18; r++) begin
      @(negedge clk);
      s_vld  = tbl[r].vld;
      s_dat  = tbl[r].dat;
      s_last = tbl[r].last;
      m_rdy  = tbl[r].rdy;
      #1;
      chk($sformatf("row%0d tvalid", r), 32'(m_vld), 32'(tbl[r].e_vld));
      chk($sformatf("row%0d tdata", r), m_dat, tbl[r].e_dat);
      chk($sformatf("row%0d tlast", r), 32'(m_last), 32'(tbl[r].e_last));
      chk($sformatf("row%0d tready", r), 32'(s_rdy), 32'(tbl[r].e_trdy));
      chk($sformatf("row%0d grant_valid", r), 32'(grant_vld), 32'(tbl[r].e_gv));
      chk($sformatf("row%0d current_grant", r), 32'(cur_grant), 32'(tbl[r].e_cg));
    end

    // Backpressure: input 1 sends a 4-beat packet and out.TREADY is low on cycles 3..7.
    // D2 is the beat presented during the stall.
    beats[0] = {1'b0, 32'h80000011};
    beats[1] = {1'b0, 32'h000000D1};
    beats[2] = {1'b0, 32'h000000D2};
    beats[3] = {1'b1, 32'h000000D3};
    begin
      int idx;
      idx = 0;
      s_vld = '0; s_dat = '0; s_last = '0;
      for (int c = 0; c < 40 && idx < 4; c++) begin
        @(negedge clk);
        s_vld[1]  = 1'b1;
        s_dat[1]  = beats[idx][31:0];
        s_last[1] = beats[idx][32];
        m_rdy     = !(c >= 3 && c <= 7);
        #1;
        if (c >= 3 && c <= 7) begin
          chk($sformatf("stall%0d tdata", c), m_dat, 32'h000000D2);
          chk($sformatf("stall%0d tvalid", c), 32'(m_vld), 1);
          chk($sformatf("stall%0d tready", c), 32'(s_rdy), 0);
          chk($sformatf("stall%0d lock", c), {29'd0, grant_vld, cur_grant}, 32'h9);
        end
        if (m_vld && m_rdy) rx_q.push_back({m_last, m_dat});
        if (s_rdy[1]) idx++;
      end
      chk("stall source drained", 32'(idx), 4);
      chk("stall beat count", 32'(rx_q.size()), 4);
      for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
        chk($sformatf("stall beat%0d", i), rx_q[i][31:0], beats[i][31:0]);
        chk($sformatf("stall last%0d", i), 32'(rx_q[i][32]), 32'(beats[i][32]));
      end
      @(negedge clk);
      s_vld = '0;
      m_rdy = 1'b1;
      #1;
      chk("stall release grant_valid", 32'(grant_vld), 0);
    end

    // Reset mid-packet: rr_ptr is 2 here. Reset is asserted during beat 2 of an input-2 packet.
    @(negedge clk);
    s_vld = 5'b00100; s_dat[2] = 32'h80000022; s_last = '0;
    @(negedge clk);
    #1;
    chk("rst pkt grant", {29'd0, grant_vld, cur_grant}, 32'hA);
    @(negedge clk);
    s_dat[2] = 32'h000000E1;
    @(negedge clk);
    s_dat[2] = 32'h000000E2;
    #1;
    chk("rst pkt beat2", m_dat, 32'h000000E2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("mid_reset", 0);
    @(negedge clk);
    rst_n = 1'b1;
    s_vld = 5'b01010;
    s_dat = '0;
    s_dat[1] = 32'h80000012;
    s_dat[3] = 32'h80000032;
    #1;
    chk("post_reset idle grant_valid", 32'(grant_vld), 0);
    @(negedge clk);
    #1;
    // The scan restarts at 0, so input 1 beats input 3. If rr_ptr had survived at 2, input 3 would win.
    chk("post_reset grant", {29'd0, grant_vld, cur_grant}, 32'h9);
    chk("post_reset tdata", m_dat, 32'h80000012);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Output-side counterpart of the router input demultiplexer: merges INPUT_NUMBER AXI-Stream inputs (one per router input port) onto one output port.
- Arbitration happens only on routing-header beats, round-robin.
- The grant locks to one input for the whole packet and is released only after the TLAST beat handshakes.
- The current grant index is exported so upstream demultiplexers can steer to it.

Parameters:
- DATA_WIDTH, 32, TDATA width; the top PACKET_TYPE_WIDTH bits carry the packet type (package constant).
- INPUT_NUMBER, 5, number of contending input streams.
- INPUT_NUMBER_WIDTH, $clog2(INPUT_NUMBER), width of the grant index.
- ID_WIDTH / DEST_WIDTH / USER_WIDTH, 4, sideband widths; present only under the existing TID_PRESENT / TDEST_PRESENT / TUSER_PRESENT macros.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in[INPUT_NUMBER], axis_if.s, DATA_WIDTH + sidebands, contending input streams.
- out, axis_if.m, DATA_WIDTH + sidebands, merged output stream.
- current_grant, output, INPUT_NUMBER_WIDTH, index of the locked or last-granted input.
- grant_valid, output, 1, high while a packet is locked (state LOCKED).

Interface notes:
- Reset is asynchronous, active-low; all state uses one clock.
- TLAST is mandatory for this block.

Behaviour:
- Header beat: TVALID=1 and TDATA[DATA_WIDTH-1 -: PACKET_TYPE_WIDTH] == ROUTING_HEADER.
- State register is 2-state: IDLE, LOCKED.
- Registers: state, grant, rr_ptr (INPUT_NUMBER_WIDTH).

Reset:
- state=IDLE, grant=0, rr_ptr=0.
- out.TVALID=0, all in[i].TREADY=0, grant_valid=0, current_grant=0.

IDLE:
- All in[i].TREADY=0; out.TVALID=0.
- Requestors are inputs presenting a header beat.
- Winner is the first requestor scanning rr_ptr, rr_ptr+1, … modulo INPUT_NUMBER.
- If any requestor exists: grant<=winner, state<=LOCKED on the next edge.
- Arbitration latency: 1 cycle from header valid to first forwarded beat.
- Non-header beats on any input in IDLE are ignored and stall (TREADY=0).

LOCKED:
- out carries in[grant] payload and sidebands; out.TVALID=in[grant].TVALID.
- in[grant].TREADY=out.TREADY; every other input sees TREADY=0.
- Headers arriving on other inputs are held, never dropped.
- On in[grant].TVALID & out.TREADY & TLAST: state<=IDLE, rr_ptr<=grant+1, wrapping to 0 when grant == INPUT_NUMBER-1.
- A single-beat packet (header with TLAST) locks for exactly one handshake.
- A header beat seen while LOCKED on the granted input is forwarded as data; no re-arbitration occurs.

Outputs and invariants:
- current_grant=grant in both states; grant_valid=(state==LOCKED).
- out payload and sidebands must not change while out.TVALID=1 and out.TREADY=0; the grant is frozen in LOCKED.
- When out.TVALID=0, out.TDATA and sidebands are driven to 0.
- Reset mid-packet: immediate return to the reset values above; the partial packet is abandoned with no recovery.
- Back-to-back packets from the same input: header → IDLE (1 cycle) → LOCKED; one bubble cycle per packet.

Optional Feature:
- Macro: ARB_OUT_SKID_EN.
- With the macro: a 2-entry skid buffer sits between the arbiter and out.
  - Arbiter-side ready is registered.
  - Adds 1 cycle of latency.
  - Full throughput is kept under backpressure.
  - The lock releases when TLAST is accepted into the skid buffer, not when it leaves out.
  - Skid entries reset to empty.
- Without the macro: combinational pass-through as described above; zero added latency.

Test Plan:
- Reset release, no traffic → out.TVALID=0, grant_valid=0, current_grant=0, all TREADY=0 for 10 cycles.
- Input 2 sends a 4-beat packet (header, 0xA1, 0xA2, 0xA3 with TLAST), out.TREADY=1 → output beats on cycles 1–4 after header valid; grant_valid falls after the TLAST beat; rr_ptr=3.
- Inputs 0 and 3 present headers simultaneously with rr_ptr=3 → input 3 granted first; input 0 granted after input 3's TLAST; input 0's header is held unchanged meanwhile.
- Mid-packet out.TREADY=0 for 5 cycles → out.TDATA stable, in[grant].TREADY=0, lock kept, no beats lost or duplicated.
- Non-header beat on input 1 while IDLE → never accepted and never granted; a header on input 4 is still granted.
- rst_n asserted during beat 2 of a 4-beat packet → state IDLE and out.TVALID=0 immediately; the next header arbitrates from rr_ptr=0.
